// File: rtl/axil_cmd_master.sv
// Bridges a single-beat valid/ready command stream onto an AXI4-Lite master port,
// one transaction in flight, returning one response word per command.
module axil_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_resp_o,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr_o,
  output logic                  m_axil_awvalid_o,
  input  logic                  m_axil_awready_i,
  output logic [2:0]            m_axil_awprot_o,
  output logic [DATA_WIDTH-1:0] m_axil_wdata_o,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb_o,
  output logic                  m_axil_wvalid_o,
  input  logic                  m_axil_wready_i,
  input  logic [1:0]            m_axil_bresp_i,
  input  logic                  m_axil_bvalid_i,
  output logic                  m_axil_bready_o,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr_o,
  output logic                  m_axil_arvalid_o,
  input  logic                  m_axil_arready_i,
  output logic [2:0]            m_axil_arprot_o,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata_i,
  input  logic [1:0]            m_axil_rresp_i,
  input  logic                  m_axil_rvalid_i,
  output logic                  m_axil_rready_o
);

  typedef enum logic [2:0] {
    IDLE, WRITE, WR_RESP, READ, RD_DATA, RSP
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_we_q, rsp_we_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  // In WRITE the AW and W valid registers double as the per-channel done flags:
  // each clears after its own handshake and the phase ends when both are clear.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          wstrb_d = cmd_wstrb_i;
          if (cmd_we_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = READ;
          end
        end
      end
      WRITE: begin
        if (awvalid_q && m_axil_awready_i) awvalid_d = 1'b0;
        if (wvalid_q && m_axil_wready_i)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axil_bvalid_i) begin
          bready_d    = 1'b0;
          rsp_resp_d  = m_axil_bresp_i;
          rsp_rdata_d = '0;
          rsp_we_d    = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      READ: begin
        if (m_axil_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axil_rvalid_i) begin
          rready_d    = 1'b0;
          rsp_resp_d  = m_axil_rresp_i;
          rsp_rdata_d = m_axil_rdata_i;
          rsp_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset drops every valid/ready at once; in-flight AXI beats are abandoned.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready_o      = (state_q == IDLE);
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_we_o         = rsp_we_q;
  assign rsp_rdata_o      = rsp_rdata_q;
  assign rsp_resp_o       = rsp_resp_q;
  assign m_axil_awaddr_o  = addr_q;
  assign m_axil_awvalid_o = awvalid_q;
  assign m_axil_awprot_o  = 3'b000;
  assign m_axil_wdata_o   = wdata_q;
  assign m_axil_wstrb_o   = wstrb_q;
  assign m_axil_wvalid_o  = wvalid_q;
  assign m_axil_bready_o  = bready_q;
  assign m_axil_araddr_o  = addr_q;
  assign m_axil_arvalid_o = arvalid_q;
  assign m_axil_arprot_o  = 3'b000;
  assign m_axil_rready_o  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: a small AXI-Lite RAM model with
// configurable ready delays and forced responses, plus per-scenario tasks.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axil_cmd_master dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_we_o(rsp_we),
    .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp),
    .m_axil_awaddr_o(awaddr), .m_axil_awvalid_o(awvalid), .m_axil_awready_i(awready),
    .m_axil_awprot_o(awprot),
    .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb), .m_axil_wvalid_o(wvalid),
    .m_axil_wready_i(wready),
    .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
    .m_axil_araddr_o(araddr), .m_axil_arvalid_o(arvalid), .m_axil_arready_i(arready),
    .m_axil_arprot_o(arprot),
    .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp), .m_axil_rvalid_i(rvalid),
    .m_axil_rready_o(rready)
  );

  // Slave model: ready pulses after N cycles of valid, B after both AW and W land.
  logic [31:0] mem [0:15];
  int          aw_delay = 1, w_delay = 1, ar_delay = 1;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_lat, w_data_lat;
  logic [3:0]  w_strb_lat;
  logic [1:0]  r_resp_cfg = 2'b00;
  logic        r_force = 1'b0;
  logic [31:0] r_force_data = '0;

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  always @(posedge clk or posedge rst) begin : slave
    logic        aw_now, w_now;
    logic [31:0] a_eff, d_eff;
    logic [3:0]  s_eff;
    if (rst) begin
      awready <= 0; wready <= 0; arready <= 0; bvalid <= 0; rvalid <= 0;
      bresp <= 0; rresp <= 0; rdata <= 0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; aw_got <= 0; w_got <= 0;
    end else begin
      awready <= 0; wready <= 0; arready <= 0;
      if (awvalid && !awready) begin
        if (aw_cnt + 1 >= aw_delay) begin awready <= 1; aw_cnt <= 0; end
        else aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && !wready) begin
        if (w_cnt + 1 >= w_delay) begin wready <= 1; w_cnt <= 0; end
        else w_cnt <= w_cnt + 1;
      end
      if (arvalid && !arready) begin
        if (ar_cnt + 1 >= ar_delay) begin arready <= 1; ar_cnt <= 0; end
        else ar_cnt <= ar_cnt + 1;
      end
      aw_now = aw_got || (awvalid && awready);
      w_now  = w_got || (wvalid && wready);
      a_eff  = (awvalid && awready) ? awaddr : aw_addr_lat;
      d_eff  = (wvalid && wready) ? wdata : w_data_lat;
      s_eff  = (wvalid && wready) ? wstrb : w_strb_lat;
      if (awvalid && awready) aw_addr_lat <= awaddr;
      if (wvalid && wready) begin w_data_lat <= wdata; w_strb_lat <= wstrb; end
      if (bvalid && bready) bvalid <= 0;
      if (aw_now && w_now) begin
        for (int i = 0; i < 4; i++)
          if (s_eff[i]) mem[a_eff[5:2]][8*i +: 8] <= d_eff[8*i +: 8];
        bvalid <= 1; bresp <= 2'b00;
        aw_got <= 0; w_got <= 0;
      end else begin
        aw_got <= aw_now; w_got <= w_now;
      end
      if (rvalid && rready) rvalid <= 0;
      if (arvalid && arready) begin
        rvalid <= 1;
        rresp  <= r_resp_cfg;
        rdata  <= r_force ? r_force_data : mem[araddr[5:2]];
      end
    end
  end

  // Handshake monitor: counts beats, timestamps them, flags withdrawn or unstable valids.
  int          cyc = 0, cmd_hs_cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, rsp_hs_cnt = 0;
  int          viol_cnt = 0;
  logic        aw_pend = 0, w_pend = 0, ar_pend = 0;
  logic [31:0] aw_prev, w_prev, ar_prev;
  logic [3:0]  s_prev;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cmd_valid && cmd_ready) cmd_hs_cyc = cyc;
    if (awvalid && awready) begin aw_hs_cnt++; aw_hs_cyc = cyc; end
    if (wvalid && wready) begin w_hs_cnt++; w_hs_cyc = cyc; end
    if (arvalid && arready) begin ar_hs_cnt++; ar_hs_cyc = cyc; end
    if (bvalid && bready) b_hs_cnt++;
    if (rsp_valid && rsp_ready) rsp_hs_cnt++;
    if (rst) begin
      aw_pend = 0; w_pend = 0; ar_pend = 0;
    end else begin
      if (aw_pend && (!awvalid || awaddr !== aw_prev)) viol_cnt++;
      if (w_pend && (!wvalid || wdata !== w_prev || wstrb !== s_prev)) viol_cnt++;
      if (ar_pend && (!arvalid || araddr !== ar_prev)) viol_cnt++;
      aw_pend = awvalid && !awready; aw_prev = awaddr;
      w_pend  = wvalid && !wready;   w_prev  = wdata; s_prev = wstrb;
      ar_pend = arvalid && !arready; ar_prev = araddr;
    end
  end

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    int n;
    @(negedge clk);
    cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL cmd_accept_timeout: cmd_ready=%b, required 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Entered at the negedge of cycle 1 after the command handshake.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 60) begin @(negedge clk); lat++; end
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rsp_timeout: rsp_valid=%b, required 1", rsp_valid);
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic check_rsp(input string name, input int lat, input int exp_lat,
                           input logic exp_we, input logic [1:0] exp_resp,
                           input logic [31:0] exp_rdata);
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++; $display("[TB] FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (rsp_we !== exp_we) begin
      n_fail++; $display("[TB] FAIL %s_we: got %b, required %b", name, rsp_we, exp_we);
    end
    n_checks++;
    if (rsp_resp !== exp_resp) begin
      n_fail++; $display("[TB] FAIL %s_resp: got %b, required %b", name, rsp_resp, exp_resp);
    end
    n_checks++;
    if (rsp_rdata !== exp_rdata) begin
      n_fail++; $display("[TB] FAIL %s_rdata: got %h, required %h", name, rsp_rdata, exp_rdata);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL %s_handshakes: aw/w/ar/b/r/rsp=%b, required 000000", name,
               {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL %s_cmd_ready: got %b, required 1", name, cmd_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    n_checks++;
    if ({awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_we, awprot, arprot} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_fields: awaddr=%h wdata=%h wstrb=%h rdata=%h resp=%b we=%b, required all 0",
               awaddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_we);
    end
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_write_read();
    int lat;
    send_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_rsp(lat);
    check_rsp("wr", lat, 4, 1'b1, 2'b00, 32'h0);
    ack_rsp();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL wr_return_idle: cmd_ready=%b, required 1", cmd_ready);
    end
    send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(lat);
    check_rsp("rd", lat, 4, 1'b0, 2'b00, 32'hDEADBEEF);
    ack_rsp();
  endtask

  task automatic test_partial_strobe();
    int lat;
    send_cmd(1'b1, 32'h20, 32'h11223344, 4'hF);
    wait_rsp(lat); ack_rsp();
    send_cmd(1'b1, 32'h20, 32'hAABBCCDD, 4'h3);
    wait_rsp(lat); ack_rsp();
    send_cmd(1'b0, 32'h20, 32'h0, 4'h0);
    wait_rsp(lat);
    check_rsp("strb", lat, 4, 1'b0, 2'b00, 32'h1122CCDD);
    ack_rsp();
  endtask

  task automatic test_aw_before_w();
    int lat, aw0, w0, b0, r0, v0;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt; r0 = rsp_hs_cnt; v0 = viol_cnt;
    w_delay = 4;
    send_cmd(1'b1, 32'h30, 32'h0BADF00D, 4'hF);
    wait_rsp(lat);
    check_rsp("split", lat, 7, 1'b1, 2'b00, 32'h0);
    ack_rsp();
    repeat (8) @(negedge clk);
    n_checks++;
    if (aw_hs_cyc - cmd_hs_cyc != 2 || w_hs_cyc - aw_hs_cyc != 3) begin
      n_fail++;
      $display("[TB] FAIL split_order: aw at +%0d w at +%0d, required +2 and +5",
               aw_hs_cyc - cmd_hs_cyc, w_hs_cyc - cmd_hs_cyc);
    end
    n_checks++;
    if (aw_hs_cnt - aw0 != 1 || w_hs_cnt - w0 != 1) begin
      n_fail++;
      $display("[TB] FAIL split_beats: aw=%0d w=%0d, required 1 and 1", aw_hs_cnt - aw0, w_hs_cnt - w0);
    end
    n_checks++;
    if (b_hs_cnt - b0 != 1 || rsp_hs_cnt - r0 != 1) begin
      n_fail++;
      $display("[TB] FAIL split_b_rsp: b=%0d rsp=%0d, required 1 and 1", b_hs_cnt - b0, rsp_hs_cnt - r0);
    end
    n_checks++;
    if (viol_cnt != v0) begin
      n_fail++; $display("[TB] FAIL split_valid_rule: violations=%0d, required 0", viol_cnt - v0);
    end
    w_delay = 1;
  endtask

  task automatic test_back_pressure();
    int lat;
    send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(lat);
    cmd_we = 1'b0; cmd_addr = 32'h20; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF ||
          rsp_we !== 1'b0 || rsp_resp !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL bp_hold_%0d: cmd_ready=%b valid=%b rdata=%h we=%b resp=%b, required 0 1 deadbeef 0 00",
                 i, cmd_ready, rsp_valid, rsp_rdata, rsp_we, rsp_resp);
      end
      @(negedge clk);
    end
    ack_rsp();
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_release: cmd_ready=%b rsp_valid=%b, required 1 0", cmd_ready, rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++;
    if (arvalid !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_next_accept: arvalid=%b cmd_ready=%b, required 1 0", arvalid, cmd_ready);
    end
    wait_rsp(lat);
    check_rsp("bp_next", lat, 4, 1'b0, 2'b00, 32'h1122CCDD);
    ack_rsp();
  endtask

  task automatic test_read_error();
    int lat, ar0, v0;
    ar0 = ar_hs_cnt; v0 = viol_cnt;
    ar_delay = 6; r_force = 1'b1; r_force_data = 32'hFFFF0000; r_resp_cfg = 2'b10;
    send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(lat);
    check_rsp("rerr", lat, 9, 1'b0, 2'b10, 32'hFFFF0000);
    ack_rsp();
    n_checks++;
    if (ar_hs_cyc - cmd_hs_cyc != 7 || ar_hs_cnt - ar0 != 1) begin
      n_fail++;
      $display("[TB] FAIL rerr_ar: hs at +%0d count %0d, required +7 count 1",
               ar_hs_cyc - cmd_hs_cyc, ar_hs_cnt - ar0);
    end
    n_checks++;
    if (viol_cnt != v0) begin
      n_fail++; $display("[TB] FAIL rerr_arvalid_held: violations=%0d, required 0", viol_cnt - v0);
    end
    ar_delay = 1; r_force = 1'b0; r_resp_cfg = 2'b00;
  endtask

  task automatic test_reset_mid();
    int lat;
    aw_delay = 5; w_delay = 5;
    send_cmd(1'b1, 32'h10, 32'h12345678, 4'hF);
    n_checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_in_write: awvalid=%b wvalid=%b cmd_ready=%b, required 1 1 0",
               awvalid, wvalid, cmd_ready);
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    aw_delay = 1; w_delay = 1;
    send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(lat);
    check_rsp("after_rst", lat, 4, 1'b0, 2'b00, 32'hDEADBEEF);
    ack_rsp();
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_aw_before_w();
    test_back_pressure();
    test_read_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
